line_window_ctrl: RTL and testbench

- Sequences the 2-tap RAM line buffer (two cascaded 400-deep, 8-bit shift registers) for 3x3 neighbourhood filters.
- Accepts a raster pixel stream, gates the line buffer's clock enable, and tracks row/column position through a frame FSM.
- Assembles the 3x3 window from the live pixel and the two tap outputs, and flags when the window is fully inside the image.
- Sits between the grayscale pixel source and the convolution/morphology stages.

---
 rtl/line_window_ctrl.sv | 151 +++++++++++++++
 tb/tb_line_window_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/line_window_ctrl.sv
// line_window_ctrl: raster stream -> 3x3 window sequencer for a 2-tap line buffer.
// Gates the line buffer, tracks frame position, emits in-image windows.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pix_in/_valid/_sof  raster pixel stream, SOF marks pixel (0,0)
//   sr_din, sr_ce       line buffer data in / advance enable
//   sr_tap1, sr_tap0    line buffer taps: pixel (r-1,c) / (r-2,c)
//   win_out/_valid      registered 3x3 window, one-cycle strobe
//   win_row, win_col    window centre position
//   frame_done, err_sof end-of-frame pulse, mid-frame SOF pulse
module line_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 400
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   pix_in,
  input  logic                    pix_in_valid,
  input  logic                    pix_in_sof,
  output logic [DATA_WIDTH-1:0]   sr_din,
  output logic                    sr_ce,
  input  logic [DATA_WIDTH-1:0]   sr_tap1,
  input  logic [DATA_WIDTH-1:0]   sr_tap0,
  output logic [9*DATA_WIDTH-1:0] win_out,
  output logic                    win_valid,
  output logic [8:0]              win_row,
  output logic [8:0]              win_col,
  output logic                    frame_done,
  output logic                    err_sof
);

  localparam logic [8:0] W_LAST = 9'(IMG_WIDTH - 1);
  localparam logic [8:0] H_LAST = 9'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    ACTIVE,
    DONE
  } state_t;

  state_t state;

  // col/row hold the position of the next pixel to arrive
  logic [8:0] col;
  logic [8:0] row;

  // stored columns c-2 (old) and c-1 (mid); index 0 = oldest row
  logic [DATA_WIDTH-1:0] col_old [3];
  logic [DATA_WIDTH-1:0] col_mid [3];
  logic [DATA_WIDTH-1:0] col_new [3];

  logic                    in_frame;
  logic                    accept;
  logic                    sof_acc;
  logic [8:0]              cur_c;
  logic [8:0]              cur_r;
  logic                    last_col;
  logic                    win_hit;
  logic [9*DATA_WIDTH-1:0] win_next;

  assign in_frame = (state == PRIME) || (state == ACTIVE);
  assign accept   = rst_n && pix_in_valid &&
                    (in_frame || (state == IDLE && pix_in_sof));
  assign sof_acc  = accept && pix_in_sof;
  assign sr_ce    = accept;
  assign sr_din   = pix_in;

  assign cur_c    = sof_acc ? 9'd0 : col;
  assign cur_r    = sof_acc ? 9'd0 : row;
  assign last_col = (cur_c == W_LAST);

  // a SOF in ACTIVE makes the pixel (0,0), so no window there
  assign win_hit  = (state == ACTIVE) && !pix_in_sof &&
                    (cur_r >= 9'd2) && (cur_c >= 9'd2);

  assign col_new[0] = sr_tap0;
  assign col_new[1] = sr_tap1;
  assign col_new[2] = pix_in;

  always_comb begin
    win_next = '0;
    for (int i = 0; i < 3; i++) begin
      win_next[DATA_WIDTH*(3*i)   +: DATA_WIDTH] = col_old[i];
      win_next[DATA_WIDTH*(3*i+1) +: DATA_WIDTH] = col_mid[i];
      win_next[DATA_WIDTH*(3*i+2) +: DATA_WIDTH] = col_new[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      col_old    <= '{default: '0};
      col_mid    <= '{default: '0};
      win_out    <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;

      if (state == DONE) begin
        state <= IDLE;
      end

      if (accept) begin
        col_old <= col_mid;
        col_mid <= col_new;

        unique case (1'b1)
          sof_acc: begin
            col     <= 9'd1;
            row     <= '0;
            state   <= PRIME;
            err_sof <= (state != IDLE);
          end
          last_col: begin
            col <= '0;
            row <= row + 9'd1;
            if (state == PRIME && cur_r == 9'd1) begin
              state <= ACTIVE;
            end
            if (state == ACTIVE && cur_r == H_LAST) begin
              row        <= '0;
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
          default: begin
            col <= col + 9'd1;
          end
        endcase

        if (win_hit) begin
          win_valid <= 1'b1;
          win_out   <= win_next;
          win_row   <= cur_r - 9'd1;
          win_col   <= cur_c - 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_window_ctrl.sv
// tb_line_window_ctrl: directed bench for line_window_ctrl, 8x6 image.
// Behavioural 2-tap line buffer; windows checked against pixel model.
module tb_line_window_ctrl;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   pix_in;
  logic            pix_in_valid;
  logic            pix_in_sof;
  logic [DW-1:0]   sr_din;
  logic            sr_ce;
  logic [DW-1:0]   sr_tap1;
  logic [DW-1:0]   sr_tap0;
  logic [9*DW-1:0] win_out;
  logic            win_valid;
  logic [8:0]      win_row;
  logic [8:0]      win_col;
  logic            frame_done;
  logic            err_sof;

  int checks = 0;
  int errors = 0;
  int nwin   = 0;

  logic [9*DW-1:0] exp_wo = '0;
  logic [8:0]      exp_wr = '0;
  logic [8:0]      exp_wc = '0;

  logic [DW-1:0] lb1 [W];
  logic [DW-1:0] lb2 [W];

  always #5 clk = ~clk;

  line_window_ctrl #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_in      (pix_in),
    .pix_in_valid(pix_in_valid),
    .pix_in_sof  (pix_in_sof),
    .sr_din      (sr_din),
    .sr_ce       (sr_ce),
    .sr_tap1     (sr_tap1),
    .sr_tap0     (sr_tap0),
    .win_out     (win_out),
    .win_valid   (win_valid),
    .win_row     (win_row),
    .win_col     (win_col),
    .frame_done  (frame_done),
    .err_sof     (err_sof)
  );

  // two cascaded W-deep shift registers, advancing on sr_ce
  assign sr_tap1 = lb1[W-1];
  assign sr_tap0 = lb2[W-1];

  always @(posedge clk) begin
    if (sr_ce) begin
      lb1[0] <= sr_din;
      lb2[0] <= lb1[W-1];
      for (int k = 1; k < W; k++) begin
        lb1[k] <= lb1[k-1];
        lb2[k] <= lb2[k-1];
      end
    end
  end

  function automatic logic [9*DW-1:0] mkwin(input int base, input int cr,
                                            input int cc);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[DW*(3*i+j) +: DW] = 8'(base + (cr - 1 + i) * 16 + (cc - 1 + j));
    return w;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // one clock: apply inputs, check sr_ce, then check registered outputs
  task automatic drive(input bit v, input bit sof, input logic [7:0] px,
                       input bit acc, input bit wv, input int wr,
                       input int wc, input int base, input bit fd,
                       input bit es);
    @(negedge clk);
    pix_in       = px;
    pix_in_valid = v;
    pix_in_sof   = sof;
    #1;
    chk("sr_ce", 72'(sr_ce), 72'(acc));
    chk("sr_din", 72'(sr_din), 72'(px));
    @(posedge clk);
    #1;
    if (wv) begin
      exp_wo = mkwin(base, wr, wc);
      exp_wr = 9'(wr);
      exp_wc = 9'(wc);
      nwin++;
    end
    chk("win_valid", 72'(win_valid), 72'(wv));
    chk("win_out", 72'(win_out), 72'(exp_wo));
    chk("win_row", 72'(win_row), 72'(exp_wr));
    chk("win_col", 72'(win_col), 72'(exp_wc));
    chk("frame_done", 72'(frame_done), 72'(fd));
    chk("err_sof", 72'(err_sof), 72'(es));
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0,
          0, 0, 0, 1'b0, 1'b0);
  endtask

  // sends a frame from (0,0) up to, not including, (stop_r,stop_c)
  task automatic send_frame(input int base, input bit stall,
                            input int stop_r, input int stop_c,
                            input bit restart);
    bit first;
    bit last;
    nwin = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (stall) begin
          idle_cycle();
          if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        first = (r == 0 && c == 0);
        last  = (r == H - 1 && c == W - 1);
        drive(1'b1, first, 8'(base + r * 16 + c), 1'b1,
              (r >= 2 && c >= 2), r - 1, c - 1, base, last,
              restart && first);
      end
    end
    chk("win_count", 72'(nwin), 72'((H - 2) * (W - 2)));
    // pixel in DONE, even with SOF, is dropped
    drive(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < W; k++) begin
      lb1[k] = 8'hEE;
      lb2[k] = 8'hDD;
    end
    rst_n        = 1'b0;
    pix_in       = 8'h5A;
    pix_in_valid = 1'b1;
    pix_in_sof   = 1'b1;

    // reset: sr_ce low and all outputs zero despite valid SOF input
    drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // valid pixels without SOF in IDLE are dropped
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // full frame, valid always high
    send_frame(0, 1'b0, H, 0, 1'b0);

    // same frame with stalls
    send_frame(0, 1'b1, H, 0, 1'b0);

    // SOF injected at (3,4): new frame restarts, err_sof pulses
    send_frame(8'h20, 1'b0, 3, 4, 1'b0);
    send_frame(8'h80, 1'b0, H, 0, 1'b1);

    // reset for two cycles at (4,5), then a clean frame
    send_frame(8'h40, 1'b0, 4, 5, 1'b0);
    rst_n  = 1'b0;
    exp_wo = '0;
    exp_wr = '0;
    exp_wc = '0;
    drive(1'b1, 1'b0, 8'h85, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h86, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle_cycle();
    send_frame(8'h08, 1'b1, H, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
